// File: rtl/dsp38_fir_sequencer_if.sv
// Bus bundle between the FIR sequencer, its sample source/result sink and the DSP38.
// The cfg_* pins travel with the bundle but feed the DSP38 directly, so only the master side sees them.
interface dsp38_fir_sequencer_if #(
    parameter int unsigned TAPS = 8
) ();
    localparam int unsigned IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic          s_valid;
    logic          s_ready;
    logic [19:0]   s_data;

    logic          coef_we;
    logic [IW-1:0] coef_addr;
    logic [17:0]   coef_data;
    logic          coef_busy;

    logic          cfg_unsigned_a;
    logic          cfg_unsigned_b;
    logic          cfg_round;
    logic          cfg_sat;
    logic [5:0]    cfg_shift_right;

    logic [19:0]   dsp_a;
    logic [17:0]   dsp_b;
    logic [2:0]    dsp_feedback;
    logic          dsp_load_acc;
    logic          dsp_subtract;
    logic [37:0]   dsp_z;

    logic          m_valid;
    logic          m_ready;
    logic [37:0]   m_data;

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data,
        output cfg_unsigned_a, cfg_unsigned_b, cfg_round, cfg_sat, cfg_shift_right,
        output dsp_z, m_ready,
        input  s_ready, coef_busy, dsp_a, dsp_b, dsp_feedback, dsp_load_acc,
        input  dsp_subtract, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data, dsp_z, m_ready,
        output s_ready, coef_busy, dsp_a, dsp_b, dsp_feedback, dsp_load_acc,
        output dsp_subtract, m_valid, m_data
    );
endinterface

// File: rtl/dsp38_fir_sequencer.sv
// Sequences TAPS multiply-accumulate cycles per sample into a DSP38 and captures its Z result.
// Optional one-entry input skid register: define DSP38_FIR_SEQ_SKID_EN.
module dsp38_fir_sequencer #(
    parameter int unsigned TAPS    = 8,
    parameter int unsigned DSP_LAT = 1
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    dsp38_fir_sequencer_if.slave bus
);
    localparam int unsigned   IW       = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned   LW       = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
    localparam logic [IW-1:0] LAST_TAP = IW'(TAPS - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(DSP_LAT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [LW-1:0] r_lat;
    logic          r_init_done;
    logic [19:0]   r_dline [TAPS];
    logic [17:0]   r_coef  [TAPS];
    logic [37:0]   r_m_data;
    logic          w_accept;
    logic          w_start;
    logic [19:0]   w_start_data;
`ifdef DSP38_FIR_SEQ_SKID_EN
    logic          r_skid_full;
    logic [19:0]   r_skid_data;
    logic          w_skid_pop;
    logic          w_skid_load;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_start_data  = bus.s_data;
`ifdef DSP38_FIR_SEQ_SKID_EN
        w_skid_pop    = 1'b0;
        bus.s_ready   = r_init_done && !r_skid_full;
`else
        bus.s_ready   = r_init_done && (r_state == ST_IDLE);
`endif
        w_accept         = bus.s_valid && bus.s_ready;
        bus.coef_busy    = (r_state != ST_IDLE);
        bus.m_valid      = (r_state == ST_HOLD);
        bus.dsp_a        = '0;
        bus.dsp_b        = '0;
        bus.dsp_feedback = '0;
        bus.dsp_load_acc = 1'b0;
        bus.dsp_subtract = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef DSP38_FIR_SEQ_SKID_EN
                if (r_skid_full) begin
                    w_start      = 1'b1;
                    w_start_data = r_skid_data;
                    w_skid_pop   = 1'b1;
                end else begin
                    w_start = w_accept;
                end
`else
                w_start = w_accept;
`endif
            end
            ST_MAC: begin
                bus.dsp_a        = r_dline[r_idx];
                bus.dsp_b        = r_coef[r_idx];
                bus.dsp_load_acc = 1'b1;
                // Tap 0 clears the accumulator and loads the first product.
                bus.dsp_feedback = (r_idx == '0) ? 3'b001 : 3'b000;
                if (r_idx == LAST_TAP) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_lat == LAST_LAT) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.m_ready) begin
                    w_state_nxt = ST_IDLE;
`ifdef DSP38_FIR_SEQ_SKID_EN
                    // A pending sample (skidded or arriving now) restarts MAC with no IDLE gap.
                    if (r_skid_full) begin
                        w_start      = 1'b1;
                        w_start_data = r_skid_data;
                        w_skid_pop   = 1'b1;
                    end else begin
                        w_start = w_accept;
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_start) w_state_nxt = ST_MAC;
`ifdef DSP38_FIR_SEQ_SKID_EN
        w_skid_load = w_accept && !w_start;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_done <= 1'b0;
            r_idx       <= '0;
            r_lat       <= '0;
            r_m_data    <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_dline[k] <= '0;
                r_coef[k]  <= '0;
            end
        end else begin
            r_init_done <= 1'b1;
            if (w_start) begin
                r_idx      <= '0;
                r_dline[0] <= w_start_data;
                for (int unsigned k = 1; k < TAPS; k++) r_dline[k] <= r_dline[k-1];
            end else if (r_state == ST_MAC) begin
                r_idx <= r_idx + IW'(1);
            end
            if (r_state == ST_MAC)   r_lat <= '0;
            if (r_state == ST_DRAIN) r_lat <= r_lat + LW'(1);
            if (r_state == ST_DRAIN && r_lat == LAST_LAT) r_m_data <= bus.dsp_z;
            if (r_state == ST_IDLE && bus.coef_we && 32'(bus.coef_addr) < TAPS)
                r_coef[bus.coef_addr] <= bus.coef_data;
        end
    end

`ifdef DSP38_FIR_SEQ_SKID_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
        end else begin
            if (w_skid_pop) r_skid_full <= 1'b0;
            if (w_skid_load) begin
                r_skid_full <= 1'b1;
                r_skid_data <= bus.s_data;
            end
        end
    end
`endif

    assign bus.m_data = r_m_data;
endmodule

// File: tb/tb_dsp38_fir_sequencer.sv
// Directed bench for dsp38_fir_sequencer (TAPS=4, DSP_LAT=1) with a behavioural DSP38 MAC model.
// Skid-register sequence is exercised when DSP38_FIR_SEQ_SKID_EN is defined.
module tb_dsp38_fir_sequencer;
    localparam int unsigned TAPS    = 4;
    localparam int unsigned DSP_LAT = 1;
    localparam int          PERIOD  = TAPS + DSP_LAT + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp38_fir_sequencer_if #(.TAPS(TAPS)) tif ();

    dsp38_fir_sequencer #(.TAPS(TAPS), .DSP_LAT(DSP_LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (tif.slave)
    );

    // DSP38 in MULTIPLY_ACCUMULATE with no pipeline registers.
    logic [37:0] ea, eb, prod, acc;
    always_comb begin
        ea   = tif.cfg_unsigned_a ? {18'b0, tif.dsp_a} : {{18{tif.dsp_a[19]}}, tif.dsp_a};
        eb   = tif.cfg_unsigned_b ? {20'b0, tif.dsp_b} : {{20{tif.dsp_b[17]}}, tif.dsp_b};
        prod = ea * eb;
    end
    always_ff @(posedge clk)
        if (tif.dsp_load_acc) acc <= ((tif.dsp_feedback == 3'b001) ? 38'd0 : acc) + prod;
    assign tif.dsp_z = acc;

    typedef struct {
        logic [19:0] sample;
        logic [37:0] exp;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_coefs(input logic [17:0] c0, c1, c2, c3);
        logic [17:0] c [4];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            tif.coef_we   = 1'b1;
            tif.coef_addr = 2'(i);
            tif.coef_data = c[i];
            @(negedge clk);
        end
        tif.coef_we = 1'b0;
    endtask

    // Returns at the negedge inside the first MAC cycle.
    task automatic send_sample(input logic [19:0] d, output int acc_cyc);
        int n = 0;
        while (tif.s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("s_ready_wait");
        tif.s_valid = 1'b1;
        tif.s_data  = d;
        @(negedge clk);
        tif.s_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_mvalid(output logic [37:0] d, output int c);
        int n = 0;
        while (tif.m_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("m_valid_wait");
        d = tif.m_data;
        c = cyc;
    endtask

    initial begin
        logic [37:0] res;
        int          ac, vc, prev_vc, bad, bad2;

        tif.s_valid = 1'b0;  tif.s_data = '0;
        tif.coef_we = 1'b0;  tif.coef_addr = '0;  tif.coef_data = '0;
        tif.cfg_unsigned_a = 1'b0;  tif.cfg_unsigned_b = 1'b0;
        tif.cfg_round = 1'b0;  tif.cfg_sat = 1'b0;  tif.cfg_shift_right = '0;
        tif.m_ready = 1'b1;

        vecs[0] = '{20'd10,     38'd10};
        vecs[1] = '{20'd20,     38'd40};
        vecs[2] = '{20'd30,     38'd100};
        vecs[3] = '{20'd0,      38'd160};
        vecs[4] = '{20'hFFFFE,  38'd168};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready",   tif.s_ready, 0);
        check("rst_m_valid",   tif.m_valid, 0);
        check("rst_m_data",    tif.m_data, 0);
        check("rst_coef_busy", tif.coef_busy, 0);
        check("rst_dsp_pins",  {tif.dsp_a, tif.dsp_b, tif.dsp_feedback, tif.dsp_load_acc, tif.dsp_subtract}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_s_ready", tif.s_ready, 1);

        // Table vectors: coef {1,2,3,4}
        load_coefs(18'd1, 18'd2, 18'd3, 18'd4);
        prev_vc = 0;
        for (int i = 0; i < 5; i++) begin
            send_sample(vecs[i].sample, ac);
            wait_mvalid(res, vc);
            check($sformatf("vec%0d_m_data", i), res, vecs[i].exp);
            if (i > 0) check($sformatf("vec%0d_period", i), vc - prev_vc, PERIOD);
            prev_vc = vc;
            @(negedge clk);
        end

        // Signed sample, feedback only on tap 0
        do_reset();
        load_coefs(18'd3, 18'd0, 18'd0, 18'd0);
        send_sample(20'hFFFFB, ac);
        for (int t = 0; t < 4; t++) begin
            check($sformatf("tap%0d_feedback", t), tif.dsp_feedback, (t == 0) ? 3'b001 : 3'b000);
            check($sformatf("tap%0d_load_acc", t), tif.dsp_load_acc, 1);
            @(negedge clk);
        end
        check("drain_pins", {tif.dsp_a, tif.dsp_b, tif.dsp_feedback, tif.dsp_load_acc}, 0);
        wait_mvalid(res, vc);
        check("signed_m_data", res, 38'h3FFFFFFFF1);
        check("signed_latency", vc - ac, TAPS + DSP_LAT);
        @(negedge clk);

        // Coefficient write during MAC is dropped; busy through MAC/DRAIN/HOLD
        tif.m_ready = 1'b0;
        send_sample(20'd1, ac);
        tif.coef_we = 1'b1;  tif.coef_addr = 2'd0;  tif.coef_data = 18'd7;
        bad = 0;
        for (int n = 0; n < 50 && tif.m_valid !== 1'b1; n++) begin
            if (tif.coef_busy !== 1'b1) bad++;
            @(negedge clk);
        end
        check("busy_mac_drain", bad, 0);
        check("busy_hold", tif.coef_busy, 1);
        tif.coef_we = 1'b0;
        wait_mvalid(res, vc);
        check("coefwr_m_data0", res, 38'd3);
        tif.m_ready = 1'b1;
        @(negedge clk);
        send_sample(20'd2, ac);
        wait_mvalid(res, vc);
        check("coefwr_old_coef", res, 38'd6);
        @(negedge clk);

        // Back-pressure: 20 cycles in HOLD
        tif.m_ready = 1'b0;
        send_sample(20'd4, ac);
        wait_mvalid(res, vc);
        check("hold_m_data", res, 38'd12);
        bad = 0;  bad2 = 0;
        repeat (20) begin
            @(negedge clk);
            if (tif.m_valid !== 1'b1 || tif.m_data !== 38'd12) bad++;
`ifndef DSP38_FIR_SEQ_SKID_EN
            if (tif.s_ready !== 1'b0) bad2++;
`endif
        end
        check("hold_stable", bad, 0);
        check("hold_s_ready_low", bad2, 0);
        tif.m_ready = 1'b1;
        @(negedge clk);
        check("hold_release_m_valid", tif.m_valid, 0);
        check("hold_release_s_ready", tif.s_ready, 1);

        // Reset mid-MAC at tap 2
        send_sample(20'd9, ac);
        repeat (2) @(negedge clk);
        check("tap2_dsp_a", tif.dsp_a, 20'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_dsp_pins", {tif.dsp_a, tif.dsp_b, tif.dsp_feedback, tif.dsp_load_acc}, 0);
        check("midrst_outs", {tif.s_ready, tif.m_valid, tif.coef_busy, tif.m_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_coefs(18'd1, 18'd2, 18'd3, 18'd4);
        send_sample(20'd5, ac);
        wait_mvalid(res, vc);
        check("postrst_m_data", res, 38'd5);
        @(negedge clk);

`ifdef DSP38_FIR_SEQ_SKID_EN
        // Back-to-back samples through the skid register
        do_reset();
        load_coefs(18'd1, 18'd2, 18'd3, 18'd4);
        tif.s_valid = 1'b1;  tif.s_data = 20'd1;
        @(negedge clk);
        tif.s_data = 20'd2;
        check("skid_ready_mac", tif.s_ready, 1);
        @(negedge clk);
        tif.s_valid = 1'b0;
        wait_mvalid(res, prev_vc);
        check("skid_m_data0", res, 38'd1);
        @(negedge clk);
        wait_mvalid(res, vc);
        check("skid_m_data1", res, 38'd4);
        check("skid_period", vc - prev_vc, TAPS + DSP_LAT + 1);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
